// File: rtl/alu_control_if.sv
// Bus between main control and the ALU-control decoder.
// Handshake: the requester raises en for exactly the cycles whose alu_op/funct
// must be decoded; valid is the registered copy of en and marks the cycle in
// which alu_ctrl/illegal carry that decode. There is no back-pressure (no
// ready), so every en = 1 edge produces exactly one result one cycle later.
interface alu_control_if;
  logic       en;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic [4:0] alu_ctrl;
  logic       illegal;
  logic       valid;

  // Main control side: drives the request, observes the decode.
  modport master (
    output en,
    output alu_op,
    output funct,
    input  alu_ctrl,
    input  illegal,
    input  valid
  );

  // Decoder side: samples the request, drives the registered decode.
  modport slave (
    input  en,
    input  alu_op,
    input  funct,
    output alu_ctrl,
    output illegal,
    output valid
  );
endinterface

// File: rtl/alu_control.sv
// Registered ALU-operation decoder. Combines the ALU op class from main
// control with the R-type funct field and registers a 5-bit ALU code, an
// illegal-funct flag and a valid strobe. One cycle latency, no combinational
// path from inputs to outputs.
module alu_control (
  input  logic          clk,
  input  logic          rst_n,
  alu_control_if.slave  bus
);

  // ALU operation codes. 01101..11111 are never produced.
  localparam logic [4:0] ALU_NOP   = 5'b00000;
  localparam logic [4:0] ALU_ADD   = 5'b00001;
  localparam logic [4:0] ALU_SUB   = 5'b00010;
  localparam logic [4:0] ALU_AND   = 5'b00011;
  localparam logic [4:0] ALU_OR    = 5'b00100;
  localparam logic [4:0] ALU_XOR   = 5'b00101;
  localparam logic [4:0] ALU_NOR   = 5'b00110;
  localparam logic [4:0] ALU_SLL   = 5'b00111;
  localparam logic [4:0] ALU_SRL   = 5'b01000;
  localparam logic [4:0] ALU_SRA   = 5'b01001;
  localparam logic [4:0] ALU_SLT   = 5'b01010;
  localparam logic [4:0] ALU_SLTU  = 5'b01011;
  localparam logic [4:0] ALU_PASSB = 5'b01100;

  // ALU op classes from main control.
  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_SLT   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  // Mapped R-type funct encodings.
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  logic [4:0] dec_ctrl;
  logic       dec_illegal;

  logic [4:0] ctrl_q;
  logic       illegal_q;
  logic       valid_q;

  // Decode the current request; funct only matters for the R-type class.
  always_comb begin
    dec_ctrl    = ALU_NOP;
    dec_illegal = 1'b0;
    unique case (bus.alu_op)
      OP_RTYPE: begin
        case (bus.funct)
          FN_SLL:  dec_ctrl = ALU_SLL;
          FN_SRL:  dec_ctrl = ALU_SRL;
          FN_SRA:  dec_ctrl = ALU_SRA;
          FN_ADD:  dec_ctrl = ALU_ADD;
          FN_SUB:  dec_ctrl = ALU_SUB;
          FN_AND:  dec_ctrl = ALU_AND;
          FN_OR:   dec_ctrl = ALU_OR;
          FN_XOR:  dec_ctrl = ALU_XOR;
          FN_NOR:  dec_ctrl = ALU_NOR;
          FN_SLT:  dec_ctrl = ALU_SLT;
          FN_SLTU: dec_ctrl = ALU_SLTU;
          default: begin
            dec_ctrl    = ALU_NOP;
            dec_illegal = 1'b1;
          end
        endcase
      end
      OP_ADD:   dec_ctrl = ALU_ADD;
      OP_SUB:   dec_ctrl = ALU_SUB;
      OP_AND:   dec_ctrl = ALU_AND;
      OP_OR:    dec_ctrl = ALU_OR;
      OP_XOR:   dec_ctrl = ALU_XOR;
      OP_SLT:   dec_ctrl = ALU_SLT;
      OP_PASSB: dec_ctrl = ALU_PASSB;
      default:  dec_ctrl = ALU_NOP;
    endcase
  end

  // Result registers: load on en, otherwise hold; valid tracks en every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= ALU_NOP;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= bus.en;
      if (bus.en) begin
        ctrl_q    <= dec_ctrl;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign bus.alu_ctrl = ctrl_q;
  assign bus.illegal  = illegal_q;
  assign bus.valid    = valid_q;

endmodule

// File: tb/tb_alu_control.sv
// Directed bench for alu_control: reset, funct sweep, op-class sweep,
// hold on en = 0, and asynchronous reset in the middle of a decode stream.
module tb_alu_control;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_control_if bus ();

  alu_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare {alu_ctrl, illegal, valid} against the expected triple.
  task automatic check(input string tag, input logic [4:0] exp_ctrl,
                       input logic exp_ill, input logic exp_vld);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {bus.alu_ctrl, bus.illegal, bus.valid};
    exp = {exp_ctrl, exp_ill, exp_vld};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed ctrl=%b ill=%b vld=%b expected ctrl=%b ill=%b vld=%b",
             tag, obs[6:2], obs[1], obs[0], exp[6:2], exp[1], exp[0]);
    end
  endtask

  // Drive one request at the falling edge, sample #1 after the rising edge.
  task automatic step(input logic en, input logic [2:0] op, input logic [5:0] fn);
    @(negedge clk);
    bus.en     = en;
    bus.alu_op = op;
    bus.funct  = fn;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] rt_funct [11];
  logic [4:0] rt_code  [11];
  logic [4:0] op_code  [8];
  logic [5:0] rnd;

  initial begin
    checks = 0;
    errors = 0;
    rt_funct = '{6'b000000, 6'b000010, 6'b000011, 6'b100000, 6'b100010, 6'b100100,
                 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011};
    rt_code  = '{5'b00111, 5'b01000, 5'b01001, 5'b00001, 5'b00010, 5'b00011,
                 5'b00100, 5'b00101, 5'b00110, 5'b01010, 5'b01011};
    op_code  = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                 5'b01010, 5'b01100};

    // Reset held with arbitrary inputs, checked before any clock edge.
    rst_n      = 1'b0;
    bus.en     = 1'b1;
    bus.alu_op = 3'b001;
    bus.funct  = 6'b100000;
    #2;
    check("reset_no_edge", 5'b00000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_en", 5'b00000, 1'b0, 1'b0);
    @(negedge clk);
    bus.en = 1'b0;
    rst_n  = 1'b1;

    // First decodes after release.
    step(1'b1, 3'b001, 6'b010101);
    check("op001_add", 5'b00001, 1'b0, 1'b1);
    step(1'b1, 3'b000, 6'b010101);
    check("rtype_unmapped", 5'b00000, 1'b1, 1'b1);

    // Back-to-back sweep of every mapped funct.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 3'b000, rt_funct[i]);
      check($sformatf("funct_%b", rt_funct[i]), rt_code[i], 1'b0, 1'b1);
    end

    // Unmapped funct boundaries.
    step(1'b1, 3'b000, 6'b000001);
    check("funct_000001", 5'b00000, 1'b1, 1'b1);
    step(1'b1, 3'b000, 6'b111111);
    check("funct_111111", 5'b00000, 1'b1, 1'b1);
    step(1'b1, 3'b000, 6'b100001);
    check("funct_100001", 5'b00000, 1'b1, 1'b1);

    // Non-zero op classes with random funct (illegal must clear).
    for (int op = 1; op < 8; op++) begin
      rnd = 6'($urandom_range(0, 63));
      step(1'b1, 3'(op), rnd);
      check($sformatf("op_%0d_fn_%b", op, rnd), op_code[op], 1'b0, 1'b1);
    end

    // Hold on en = 0.
    step(1'b1, 3'b100, 6'b000000);
    check("load_or", 5'b00100, 1'b0, 1'b1);
    step(1'b0, 3'b000, 6'b111111);
    check("hold_or_1", 5'b00100, 1'b0, 1'b0);
    step(1'b0, 3'b111, 6'b100010);
    check("hold_or_2", 5'b00100, 1'b0, 1'b0);
    step(1'b1, 3'b000, 6'b011111);
    check("load_illegal", 5'b00000, 1'b1, 1'b1);
    step(1'b0, 3'b010, 6'b000000);
    check("hold_illegal", 5'b00000, 1'b1, 1'b0);

    // Reset pulse between edges during a back-to-back stream.
    step(1'b1, 3'b011, 6'b101010);
    check("stream_and", 5'b00011, 1'b0, 1'b1);
    step(1'b1, 3'b000, 6'b000011);
    check("stream_sra", 5'b01001, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 5'b00000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'b101, 6'b000000);
    check("after_reset_xor", 5'b00101, 1'b0, 1'b1);
    step(1'b1, 3'b000, 6'b100111);
    check("after_reset_nor", 5'b00110, 1'b0, 1'b1);
    step(1'b0, 3'b000, 6'b000000);
    check("final_idle", 5'b00110, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
